w5300_bus_if: RTL and testbench

Physical parallel-bus driver for the WIZnet W5300, in 16-bit direct-address mode. It sits directly downstream of the UDP configuration/communication FSM. It takes that FSM's command word `caddr` and `wr_data`, and runs one timed read or write cycle on the chip pins. It returns `rd_data` and a one-cycle `op_status` completion pulse. It also runs the W5300 hardware-reset and PLL-lock power-up sequence, and signals its end with an `op_status` pulse.

---
 rtl/w5300_bus_if.sv | 213 +++++++++++++++++++++
 tb/tb_w5300_bus_if.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_bus_if.sv
// -----------------------------------------------------------------------------
// w5300_bus_if
//
// Parallel-bus driver for the WIZnet W5300 in 16-bit direct-address mode.
// It runs the chip's hardware-reset and PLL-lock wait after power-up. It then
// executes one timed read or write cycle per command word from the upstream
// UDP FSM.
//
// Ports
//   clk        in   system clock (100 MHz nominal)
//   rst_n      in   asynchronous, active-low reset
//   caddr      in   [11] 0 = request present, [10] 1 = read / 0 = write,
//                   [9:0] W5300 byte address (bit 0 passed through as-is)
//   wr_data    in   write data, captured when a request is accepted
//   rd_data    out  last completed read value, held until the next read ends
//   op_status  out  one-cycle pulse: power-up sequence done or access done
//   w_rst_n    out  W5300 RESET#
//   w_cs_n     out  W5300 CS#
//   w_rd_n     out  W5300 RD#
//   w_wr_n     out  W5300 WR#
//   w_addr     out  W5300 ADDR[9:0]
//   w_data     io   W5300 DATA[15:0], driven only while a write is in progress
//
// Handshake: the interface has no ready signal. A request is taken in any
// IDLE cycle that sees caddr[11]==0. Completion is the op_status pulse. The
// caller changes caddr during the GAP window that follows the pulse.
//
// Every output comes from a register. The always_comb block computes the
// next value of each register, so pins only change on a clk edge.
// -----------------------------------------------------------------------------
module w5300_bus_if #(
    parameter int RESET_CYCLES    = 256,
    parameter int PLL_WAIT_CYCLES = 1000000,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 7,
    parameter int HOLD_CYCLES     = 1,
    parameter int GAP_CYCLES      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] caddr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_status,
    output logic        w_rst_n,
    output logic        w_cs_n,
    output logic        w_rd_n,
    output logic        w_wr_n,
    output logic [9:0]  w_addr,
    inout  wire  [15:0] w_data
);

    // A zero-length phase would have no cycle in which to leave, so 0 means 1.
    localparam int R_EFF  = (RESET_CYCLES    < 1) ? 1 : RESET_CYCLES;
    localparam int P_EFF  = (PLL_WAIT_CYCLES < 1) ? 1 : PLL_WAIT_CYCLES;
    localparam int S_EFF  = (SETUP_CYCLES    < 1) ? 1 : SETUP_CYCLES;
    localparam int ST_EFF = (STROBE_CYCLES   < 1) ? 1 : STROBE_CYCLES;
    localparam int H_EFF  = (HOLD_CYCLES     < 1) ? 1 : HOLD_CYCLES;
    localparam int G_EFF  = (GAP_CYCLES      < 1) ? 1 : GAP_CYCLES;

    // One phase counter is shared by all states. It is wide enough for the
    // longest phase and counts 0 .. phase_length-1.
    localparam int MAX_A   = (R_EFF > P_EFF) ? R_EFF : P_EFF;
    localparam int MAX_B   = (S_EFF > ST_EFF) ? S_EFF : ST_EFF;
    localparam int MAX_C   = (H_EFF > G_EFF) ? H_EFF : G_EFF;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_EFF = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W   = (MAX_EFF <= 2) ? 1 : $clog2(MAX_EFF);

    localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(R_EFF - 1);
    localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(P_EFF - 1);
    localparam logic [CNT_W-1:0] S_LAST  = CNT_W'(S_EFF - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(ST_EFF - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_EFF - 1);
    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(G_EFF - 1);

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        PLL_WAIT = 3'd1,
        IDLE     = 3'd2,
        SETUP    = 3'd3,
        STROBE   = 3'd4,
        HOLD     = 3'd5,
        GAP      = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             op_rd, op_rd_n;       // latched op: 1 = read
    logic [15:0]      data_out, data_out_n; // latched write data
    logic             data_oe, data_oe_n;
    logic [15:0]      rd_data_n;
    logic             op_status_n;
    logic             w_rst_n_n, w_cs_n_n, w_rd_n_n, w_wr_n_n;
    logic [9:0]       w_addr_n;

    assign w_data = data_oe ? data_out : 16'hzzzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_HOLD;
            cnt       <= '0;
            op_rd     <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            rd_data   <= '0;
            op_status <= 1'b0;
            w_rst_n   <= 1'b0;
            w_cs_n    <= 1'b1;
            w_rd_n    <= 1'b1;
            w_wr_n    <= 1'b1;
            w_addr    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_rd     <= op_rd_n;
            data_out  <= data_out_n;
            data_oe   <= data_oe_n;
            rd_data   <= rd_data_n;
            op_status <= op_status_n;
            w_rst_n   <= w_rst_n_n;
            w_cs_n    <= w_cs_n_n;
            w_rd_n    <= w_rd_n_n;
            w_wr_n    <= w_wr_n_n;
            w_addr    <= w_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        op_rd_n     = op_rd;
        data_out_n  = data_out;
        data_oe_n   = data_oe;
        rd_data_n   = rd_data;
        op_status_n = 1'b0;
        w_rst_n_n   = w_rst_n;
        w_cs_n_n    = w_cs_n;
        w_rd_n_n    = w_rd_n;
        w_wr_n_n    = w_wr_n;
        w_addr_n    = w_addr;

        case (state)
            RST_HOLD: begin
                w_rst_n_n = 1'b0;
                if (cnt == R_LAST) begin
                    state_n   = PLL_WAIT;
                    cnt_n     = '0;
                    w_rst_n_n = 1'b1;
                end
            end
            PLL_WAIT: begin
                if (cnt == P_LAST) begin
                    state_n     = GAP;
                    cnt_n       = '0;
                    op_status_n = 1'b1;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (!caddr[11]) begin
                    // From here on only these latched copies are used, so
                    // later changes on caddr/wr_data cannot disturb the cycle.
                    state_n    = SETUP;
                    op_rd_n    = caddr[10];
                    w_addr_n   = caddr[9:0];
                    data_out_n = wr_data;
                    data_oe_n  = ~caddr[10];
                    w_cs_n_n   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == S_LAST) begin
                    state_n = STROBE;
                    cnt_n   = '0;
                    if (op_rd) w_rd_n_n = 1'b0;
                    else       w_wr_n_n = 1'b0;
                end
            end
            STROBE: begin
                if (cnt == ST_LAST) begin
                    state_n  = HOLD;
                    cnt_n    = '0;
                    w_rd_n_n = 1'b1;
                    w_wr_n_n = 1'b1;
                    // Sample the bus while RD# is still low, on the final
                    // strobe cycle, when the chip's output has settled longest.
                    if (op_rd) rd_data_n = w_data;
                end
            end
            HOLD: begin
                if (cnt == H_LAST) begin
                    state_n     = GAP;
                    cnt_n       = '0;
                    w_cs_n_n    = 1'b1;
                    data_oe_n   = 1'b0;
                    op_status_n = 1'b1;
                end
            end
            GAP: begin
                if (cnt == G_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = RST_HOLD;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_w5300_bus_if.sv
// -----------------------------------------------------------------------------
// Directed testbench for w5300_bus_if. It uses short power-up parameters.
// A small chip model drives DATA while CS# and RD# are both low. Pull-ups
// make a released bus read as 16'hFFFF.
// -----------------------------------------------------------------------------
module tb_w5300_bus_if;

    localparam int RC = 4;
    localparam int PC = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [11:0] caddr   = 12'h800;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] chip_rd = 16'h0000;

    wire  [15:0] rd_data;
    wire         op_status;
    wire         w_rst_n, w_cs_n, w_rd_n, w_wr_n;
    wire  [9:0]  w_addr;
    wire  [15:0] w_data;

    int vectors     = 0;
    int miscompares = 0;

    // Results gathered by do_access.
    int acc_n, acc_cs_low, acc_rd_low, acc_wr_low, acc_bad_addr, acc_bad_data;
    logic        acc_cs_at_op;
    logic [15:0] acc_data_at_op;
    logic [15:0] acc_rd_at_op;

    always #5 clk = ~clk;

    assign w_data = (!w_rd_n && !w_cs_n) ? chip_rd : 16'hzzzz;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pull
            pullup (w_data[gi]);
        end
    endgenerate

    w5300_bus_if #(
        .RESET_CYCLES    (RC),
        .PLL_WAIT_CYCLES (PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .caddr     (caddr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .op_status (op_status),
        .w_rst_n   (w_rst_n),
        .w_cs_n    (w_cs_n),
        .w_rd_n    (w_rd_n),
        .w_wr_n    (w_wr_n),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    // Issue one request in IDLE and observe it until op_status. The request
    // is presented before the accepting edge, so n counts edges from the
    // request to the pulse. If chg is set, caddr/wr_data are overwritten at
    // the first strobe cycle. Otherwise the request is withdrawn after accept.
    task automatic do_access(input logic [11:0] cmd, input logic [15:0] wd,
                             input logic [15:0] exp_pin, input logic chg);
        logic changed;
        changed      = 1'b0;
        acc_n        = 0;
        acc_cs_low   = 0;
        acc_rd_low   = 0;
        acc_wr_low   = 0;
        acc_bad_addr = 0;
        acc_bad_data = 0;
        caddr   = cmd;
        wr_data = wd;
        do begin
            @(negedge clk);
            acc_n++;
            if (w_cs_n === 1'b0) begin
                acc_cs_low++;
                if (w_addr !== cmd[9:0]) acc_bad_addr++;
                if (cmd[10]) begin
                    if (w_rd_n === 1'b0) begin
                        if (w_data !== chip_rd) acc_bad_data++;
                    end else if (w_data !== 16'hFFFF) acc_bad_data++;
                end else if (w_data !== exp_pin) acc_bad_data++;
            end
            if (w_rd_n === 1'b0) acc_rd_low++;
            if (w_wr_n === 1'b0) acc_wr_low++;
            if (!chg && acc_n == 1) caddr = 12'h800;
            if (chg && !changed && (w_rd_n === 1'b0 || w_wr_n === 1'b0)) begin
                caddr   = 12'h226;
                wr_data = 16'hFFFF;
                changed = 1'b1;
            end
        end while (op_status !== 1'b1 && acc_n < 40);
        acc_cs_at_op   = w_cs_n;
        acc_data_at_op = w_data;
        acc_rd_at_op   = rd_data;
        caddr = 12'h800;
    endtask

    task automatic wait_idle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (w_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_w_rst_n: got %b want 0", w_rst_n); end
        vectors++; if (w_cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_w_cs_n: got %b want 1", w_cs_n); end
        vectors++; if ({w_rd_n, w_wr_n} !== 2'b11) begin miscompares++; $display("FAIL reset_strobes: got %b want 11", {w_rd_n, w_wr_n}); end
        vectors++; if (w_addr !== 10'h000) begin miscompares++; $display("FAIL reset_w_addr: got %h want 000", w_addr); end
        vectors++; if (w_data !== 16'hFFFF) begin miscompares++; $display("FAIL reset_w_data_released: got %h want FFFF", w_data); end
        vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        vectors++; if (op_status !== 1'b0) begin miscompares++; $display("FAIL reset_op_status: got %b want 0", op_status); end
    endtask

    // Release reset and check the RESET# width, the PLL wait and the single
    // done pulse, with CS# idle throughout.
    task automatic test_powerup(input string tag);
        int k, m, cs_act, rst_drop;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (w_rst_n !== 1'b1 && k < 40);
        vectors++; if (k != RC) begin miscompares++; $display("FAIL %s_rst_low_cycles: got %0d want %0d", tag, k, RC); end
        m = 0; cs_act = 0; rst_drop = 0;
        do begin
            @(negedge clk);
            m++;
            if (w_cs_n !== 1'b1) cs_act++;
            if (w_rst_n !== 1'b1) rst_drop++;
        end while (op_status !== 1'b1 && m < 40);
        vectors++; if (m != PC) begin miscompares++; $display("FAIL %s_pll_wait_cycles: got %0d want %0d", tag, m, PC); end
        vectors++; if (cs_act != 0) begin miscompares++; $display("FAIL %s_cs_before_done: got %0d want 0", tag, cs_act); end
        vectors++; if (rst_drop != 0) begin miscompares++; $display("FAIL %s_rst_drop: got %0d want 0", tag, rst_drop); end
        @(negedge clk);
        vectors++; if (op_status !== 1'b0) begin miscompares++; $display("FAIL %s_done_pulse_width: got %b want 0", tag, op_status); end
    endtask

    task automatic test_read();
        wait_idle();
        chip_rd = 16'h1234;
        do_access(12'h624, 16'h0000, 16'hFFFF, 1'b0);
        vectors++; if (acc_n != 10) begin miscompares++; $display("FAIL read_latency: got %0d want 10", acc_n); end
        vectors++; if (acc_rd_low != 7) begin miscompares++; $display("FAIL read_rd_low: got %0d want 7", acc_rd_low); end
        vectors++; if (acc_wr_low != 0) begin miscompares++; $display("FAIL read_wr_low: got %0d want 0", acc_wr_low); end
        vectors++; if (acc_cs_low != 9) begin miscompares++; $display("FAIL read_cs_low: got %0d want 9", acc_cs_low); end
        vectors++; if (acc_bad_addr != 0) begin miscompares++; $display("FAIL read_addr: got %0d bad want 0", acc_bad_addr); end
        vectors++; if (acc_bad_data != 0) begin miscompares++; $display("FAIL read_bus_tristate: got %0d bad want 0", acc_bad_data); end
        vectors++; if (acc_rd_at_op !== 16'h1234) begin miscompares++; $display("FAIL read_rd_data_at_op: got %h want 1234", acc_rd_at_op); end
        vectors++; if (acc_cs_at_op !== 1'b1) begin miscompares++; $display("FAIL read_cs_at_op: got %b want 1", acc_cs_at_op); end
        chip_rd = 16'hBEEF;
        repeat (3) @(negedge clk);
        vectors++; if (rd_data !== 16'h1234) begin miscompares++; $display("FAIL read_rd_data_held: got %h want 1234", rd_data); end
    endtask

    task automatic test_write();
        wait_idle();
        do_access(12'h214, 16'hC0A8, 16'hC0A8, 1'b0);
        vectors++; if (acc_n != 10) begin miscompares++; $display("FAIL write_latency: got %0d want 10", acc_n); end
        vectors++; if (acc_wr_low != 7) begin miscompares++; $display("FAIL write_wr_low: got %0d want 7", acc_wr_low); end
        vectors++; if (acc_rd_low != 0) begin miscompares++; $display("FAIL write_rd_low: got %0d want 0", acc_rd_low); end
        vectors++; if (acc_cs_low != 9) begin miscompares++; $display("FAIL write_cs_low: got %0d want 9", acc_cs_low); end
        vectors++; if (acc_bad_addr != 0) begin miscompares++; $display("FAIL write_addr: got %0d bad want 0", acc_bad_addr); end
        vectors++; if (acc_bad_data != 0) begin miscompares++; $display("FAIL write_data: got %0d bad want 0", acc_bad_data); end
        vectors++; if (acc_data_at_op !== 16'hFFFF) begin miscompares++; $display("FAIL write_bus_release: got %h want FFFF", acc_data_at_op); end
        vectors++; if (rd_data !== 16'h1234) begin miscompares++; $display("FAIL write_rd_data_kept: got %h want 1234", rd_data); end
    endtask

    // A held request repeats every 13 edges: 9 in the access, 3 in GAP, 1 in IDLE.
    task automatic test_held_request();
        int n, falls, first_fall, second_fall;
        logic prev_cs;
        wait_idle();
        caddr = 12'h202; wr_data = 16'h5555;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (op_status !== 1'b1 && n < 40);
        vectors++; if (n != 10) begin miscompares++; $display("FAIL held_first_latency: got %0d want 10", n); end
        falls = 0; first_fall = 0; second_fall = 0; prev_cs = w_cs_n;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (prev_cs === 1'b1 && w_cs_n === 1'b0) begin
                falls++;
                if (falls == 1) first_fall = i;
                if (falls == 2) second_fall = i;
            end
            prev_cs = w_cs_n;
        end
        caddr = 12'h800;
        vectors++; if (first_fall != 4) begin miscompares++; $display("FAIL held_restart_delay: got %0d want 4", first_fall); end
        vectors++; if (falls != 2 || second_fall != 17) begin miscompares++; $display("FAIL held_access_count: got %0d at %0d want 2 at 17", falls, second_fall); end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_mid_change();
        wait_idle();
        do_access(12'h030, 16'hA5A5, 16'hA5A5, 1'b1);
        vectors++; if (acc_bad_addr != 0) begin miscompares++; $display("FAIL midchg_addr: got %0d bad want 0", acc_bad_addr); end
        vectors++; if (acc_bad_data != 0) begin miscompares++; $display("FAIL midchg_data: got %0d bad want 0", acc_bad_data); end
        vectors++; if (acc_n != 10 || acc_wr_low != 7) begin miscompares++; $display("FAIL midchg_timing: got %0d/%0d want 10/7", acc_n, acc_wr_low); end
    endtask

    task automatic test_reset_mid_access();
        int n;
        wait_idle();
        caddr = 12'h010; wr_data = 16'h1111;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (w_wr_n !== 1'b0 && n < 20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        caddr = 12'h800;
        #1;
        vectors++; if ({w_cs_n, w_rd_n, w_wr_n} !== 3'b111) begin miscompares++; $display("FAIL rstmid_ctrl: got %b want 111", {w_cs_n, w_rd_n, w_wr_n}); end
        vectors++; if (w_rst_n !== 1'b0) begin miscompares++; $display("FAIL rstmid_w_rst_n: got %b want 0", w_rst_n); end
        vectors++; if (w_data !== 16'hFFFF) begin miscompares++; $display("FAIL rstmid_w_data: got %h want FFFF", w_data); end
        vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL rstmid_rd_data: got %h want 0000", rd_data); end
        repeat (2) @(negedge clk);
        test_powerup("repower");
        wait_idle();
        chip_rd = 16'h0ABC;
        do_access(12'h40E, 16'h0000, 16'hFFFF, 1'b0);
        vectors++; if (acc_n != 10 || acc_rd_at_op !== 16'h0ABC) begin miscompares++; $display("FAIL rstmid_after_read: got %0d/%h want 10/0ABC", acc_n, acc_rd_at_op); end
    endtask

    initial begin
        test_reset();
        test_powerup("powerup");
        test_read();
        test_write();
        test_held_request();
        test_mid_change();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
